// File: rtl/multdiv_seq_ctrl.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring) sequencer driving a shared adder.
// Optional MULTDIV_ABORT_EN: a start pulse while an op is in flight restarts with the new op.
module multdiv_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_MITER, S_DPRE, S_DITER, S_DPOST, S_DONE} state_t;

  localparam logic [5:0] LAST_M = 6'(ITERS);
  localparam logic [5:0] LAST_D = 6'(ITERS - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] h, l, m;
  logic             q, neg, dz;
  logic [5:0]       cnt;
  logic             start, take;
  logic [WIDTH-1:0] rp, src;
  logic [WIDTH:0]   hl;

  assign start = ctrl_mult | ctrl_div;
`ifdef MULTDIV_ABORT_EN
  assign take = start && (state != S_DONE);
`else
  assign take = start && (state == S_IDLE);
`endif

  // Divide partial remainder after the left shift; R < D <= 2^31 keeps it in 32 bits.
  assign rp = {h[WIDTH-2:0], l[WIDTH-1]};
  assign hl = {h, l[WIDTH-1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (take) begin
      if (ctrl_mult)                 state_nx = S_MITER;
      else if (data_operandB == '0)  state_nx = S_DPOST;
      else                           state_nx = S_DPRE;
    end else begin
      case (state)
        S_MITER: if (cnt == LAST_M) state_nx = S_DONE;
        S_DPRE:  if (cnt[0])        state_nx = S_DITER;
        S_DITER: if (cnt == LAST_D) state_nx = S_DPOST;
        S_DPOST: state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    src     = '0;
    case (state)
      S_MITER: begin
        if (cnt != LAST_M) begin
          add_a = h;
          case ({l[0], q})
            2'b01:   add_b = m;
            2'b10:   begin add_b = ~m; add_cin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_DPRE: begin
        // Cycle 0 takes |dividend| (held in l), cycle 1 takes |divisor| (held in m).
        src     = cnt[0] ? m : l;
        add_a   = src[WIDTH-1] ? ~src : src;
        add_cin = src[WIDTH-1];
      end
      S_DITER: begin
        add_a   = rp;
        add_b   = ~m;
        add_cin = 1'b1;
      end
      S_DPOST: begin
        if (!dz) begin
          add_a   = neg ? ~l : l;
          add_cin = neg;
        end
      end
      default: ;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign data_resultRDY = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h              <= '0;
      l              <= '0;
      m              <= '0;
      q              <= 1'b0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (take) begin
      h   <= '0;
      q   <= 1'b0;
      cnt <= '0;
      neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz  <= !ctrl_mult && (data_operandB == '0);
      if (ctrl_mult) begin
        m <= data_operandA;
        l <= data_operandB;
      end else begin
        l <= data_operandA;
        m <= data_operandB;
      end
    end else begin
      case (state)
        S_MITER: begin
          if (cnt != LAST_M) begin
            // Overflow-corrected sign keeps the arithmetic shift exact when H+-M wraps.
            h   <= {add_sum[WIDTH-1] ^ add_ovf, add_sum[WIDTH-1:1]};
            l   <= {add_sum[0], l[WIDTH-1:1]};
            q   <= l[0];
            cnt <= cnt + 6'd1;
          end else begin
            data_result    <= l;
            data_exception <= !((&hl) || (~|hl));
          end
        end
        S_DPRE: begin
          if (!cnt[0]) begin
            l   <= add_sum;
            cnt <= 6'd1;
          end else begin
            m   <= add_sum;
            h   <= '0;
            cnt <= '0;
          end
        end
        S_DITER: begin
          if (add_cout) begin
            h <= add_sum;
            l <= {l[WIDTH-2:0], 1'b1};
          end else begin
            h <= rp;
            l <= {l[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
        end
        S_DPOST: begin
          if (dz) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end else begin
            data_result    <= add_sum;
            data_exception <= (l == {1'b1, {(WIDTH-1){1'b0}}}) && !neg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Self-checking bench for multdiv_seq_ctrl: table vectors, random ops vs a behavioural model, corner sequences.
module tb_multdiv_seq_ctrl;

  logic        clock = 1'b0, reset_n = 1'b0, ctrl_mult = 1'b0, ctrl_div = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic [31:0] add_a, add_b, add_sum, data_result;
  logic        add_cin, add_cout, add_ovf, data_exception, data_resultRDY, busy;
  logic [32:0] sum33;
  logic [31:0] lo32;

  multdiv_seq_ctrl #(.WIDTH(32), .ITERS(32)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .data_operandA(opa), .data_operandB(opb),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  // Shared adder model
  always_comb begin
    sum33 = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
    lo32  = {1'b0, add_a[30:0]} + {1'b0, add_b[30:0]} + 32'(add_cin);
  end
  assign add_sum  = sum33[31:0];
  assign add_cout = sum33[32];
  assign add_ovf  = sum33[32] ^ lo32[31];

  typedef struct {bit mult; logic [31:0] a, b, res; bit exc; int lat;} vec_t;
  typedef struct {logic [31:0] res; bit exc; int e0; int lat;} exp_t;

  vec_t vt[14];
  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic void model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e, output int lat);
    longint p;
    if (mult) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      e   = (p != longint'($signed(p[31:0])));
      lat = 33;
    end else if (b == 32'd0) begin
      r = '0; e = 1'b1; lat = 1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000; e = 1'b1; lat = 35;
    end else begin
      r = $signed(a) / $signed(b); e = 1'b0; lat = 35;
    end
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset_n && data_resultRDY) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_rdy: got rdy=1 want none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("exception", 32'(data_exception), 32'(e.exc));
        chk("latency", 32'(cyc - e.e0), 32'(e.lat));
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic start_op(input bit mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input bit e, input int lat);
    exp_t x;
    @(posedge clock); #1;
    ctrl_mult = mult; ctrl_div = !mult; opa = a; opb = b;
    x = '{r, e, cyc + 1, lat};
    sb.push_back(x);
    @(posedge clock); #1;
    ctrl_mult = 1'b0; ctrl_div = 1'b0; opa = $urandom; opb = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(posedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rr;
    bit          re, rm, seen;
    int          rl;

    vt[0]  = '{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33};
    vt[1]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 33};
    vt[2]  = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33};
    vt[3]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 33};
    vt[4]  = '{1'b1, 32'h00010000, 32'h00010000, 32'd0,        1'b1, 33};
    vt[5]  = '{1'b1, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1, 33};
    vt[6]  = '{1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 35};
    vt[7]  = '{1'b0, 32'd5,        32'd0,        32'd0,        1'b1, 1};
    vt[8]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 35};
    vt[9]  = '{1'b0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 35};
    vt[10] = '{1'b0, 32'd7,        32'd100,      32'd0,        1'b0, 35};
    vt[11] = '{1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 35};
    vt[12] = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 35};
    vt[13] = '{1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0, 35};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    foreach (vt[i]) begin
      start_op(vt[i].mult, vt[i].a, vt[i].b, vt[i].res, vt[i].exc, vt[i].lat);
      wait_idle();
    end

    for (int i = 0; i < 8; i++) begin
      rm = i[0];
      ra = $urandom;
      rb = (i < 4) ? $urandom : 32'($urandom_range(1, 1000)) ^ {32{ra[0]}};
      model(rm, ra, rb, rr, re, rl);
      start_op(rm, ra, rb, rr, re, rl);
      wait_idle();
    end

    // Start pulse 10 cycles into a multiply: ignored by default, restarts when aborts are enabled.
    start_op(1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
    repeat (9) @(posedge clock);
    #1;
    ctrl_mult = 1'b1; opa = 32'd3; opb = 32'd5;
`ifdef MULTDIV_ABORT_EN
    sb.delete();
    sb.push_back('{32'd15, 1'b0, cyc + 1, 33});
`endif
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    wait_idle();

    // A start in the DONE cycle is ignored.
    start_op(1'b0, 32'd50, 32'd5, 32'd10, 1'b0, 35);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      seen = data_resultRDY;
    end
    chk("done_seen", 32'(seen), 32'd1);
    ctrl_div = 1'b1; opa = 32'd9; opb = 32'd0;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    @(negedge clock);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    repeat (5) @(posedge clock);

    // First Booth step for B odd, then reset mid-multiply.
    start_op(1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
    @(negedge clock);
    chk("booth_first_a", add_a, 32'd0);
    chk("booth_first_b", add_b, 32'hFFFFFFF8);
    chk("booth_first_cin", 32'(add_cin), 32'd1);
    repeat (9) @(posedge clock);
    #1 reset_n = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_exc", 32'(data_exception), 32'd0);
    chk("midrst_rdy", 32'(data_resultRDY), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_add_b", add_b, 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
